mii_rx_deframer: RTL and testbench
==================================

# mii_rx_deframer

Receive-side deframer for the 64-bit/8-lane MII datapath: the opposite end of the frame generator. It watches raw MII words (data + per-lane control flags), recognises start / preamble / SFD / terminate / error characters, strips framing and emits payload bytes as a byte-enabled word stream with last and error markers. It sits between the MII interface and the MAC receive logic. It also keeps saturating frame and error counters.

## Interface
- DATA_WIDTH, 64, MII data width; must equal 8*CTRL_WIDTH
- CTRL_WIDTH, 8, number of byte lanes / control flags
- MAX_BYTES, 1518, maximum payload bytes per frame (SFD excluded, FCS included)
- clk  input  1  single clock; all logic on rising edge
- i_rst  input  1  asynchronous, active-high reset
- i_rx_data  input  DATA_WIDTH  MII data; lane k = bits [8k+7:8k], lane 0 first on wire
- i_rx_ctrl  input  CTRL_WIDTH  bit k = 1 marks lane k as a control character
- o_data  output  DATA_WIDTH  payload bytes, lane 0 = earliest byte
- o_keep  output  CTRL_WIDTH  valid-byte mask, contiguous from bit 0
- o_valid  output  1  beat valid; no backpressure
- o_last  output  1  final beat of frame
- o_err  output  1  frame aborted/bad; qualified by o_valid & o_last
- o_frame_cnt  output  16  good frames delivered, saturating at 0xFFFF
- o_err_cnt  output  16  errored/dropped frames, saturating at 0xFFFF

## Operation
- Characters: idle 0x07/ctrl, start 0xFB/ctrl (lane 0 only), terminate 0xFD/ctrl, error 0xFE/ctrl, preamble 0x55, SFD 0xD5.
- States IDLE, DATA, DROP.
- IDLE: word with lane 0 = 0xFB ctrl, ctrl[7:1]=0, lanes 1..6 = 0x55, lane 7 = 0xD5 -> DATA, byte count cleared. Start with bad preamble/SFD -> DROP, o_err_cnt +1. Anything else ignored.
- DATA, word with no ctrl bits: 8 payload bytes, byte count +8.
- DATA, first ctrl lane k holds 0xFD: bytes 0..k-1 are final payload; -> IDLE. k=0: previous beat gets o_last.
- DATA, first ctrl lane holds anything else (0xFE, 0xFB, 0x07, ...): abort. Bytes before it discarded; previous held beat emitted with o_last=1, o_err=1; -> DROP.
- DATA, byte count would exceed MAX_BYTES: same abort, bytes of the overflowing word discarded.
- DROP: stays until a word with any 0xFD lane or all lanes idle -> IDLE. A start in DROP is ignored.
- Zero-payload frame (start followed by 0xFD in lane 0): no beat emitted, o_err_cnt +1.
- Counters: o_frame_cnt +1 on each o_last with o_err=0; o_err_cnt +1 on each o_last with o_err=1 and on each dropped start; both saturate.

## Timing
- One-word hold register: each payload word is held until its successor is sampled, so o_last can land on the correct beat.
- Word W sampled at edge e: its beat is on o_* after edge e+1 (valid in the second cycle after W is on the inputs), all registered.
- Terminate in lane k>0 at edge e_t: previous word output after e_t with o_last=0; partial word (o_keep=(1<<k)-1, o_last=1) output after e_t+1.
- Terminate in lane 0 at edge e_t: previous word output after e_t with o_last=1, o_keep=0xFF.
- o_valid is high for one cycle per beat; payload beats are back-to-back while the frame runs.
- Start sampled the cycle right after a terminate word: accepted. The pending partial beat still emits; the new frame's first beat follows without overlap.
- Reset (any time, asynchronous): state IDLE, hold cleared; o_data=0, o_keep=0, o_valid=0, o_last=0, o_err=0, both counters 0. A frame cut by reset gets no last beat.

## Test plan
- 64-byte frame: start word, 8 data words, word with 0xFD in lane 0 -> 8 beats, o_keep=0xFF, o_last on beat 8, o_err=0, o_frame_cnt=1.
- 61-byte frame: 7 full words, then 5 data bytes with 0xFD in lane 5 -> 8 beats, last o_keep=0x1F, first beat 2 cycles after first data word.
- 0xFE in lane 3 mid-frame after 4 words -> 4 beats, 4th with o_last=1, o_err=1; o_err_cnt=1; later good frame decodes normally.
- Start with lane 7 = 0x55 (bad SFD) -> no beats, o_err_cnt=1; a following good frame gives o_frame_cnt=1.
- MAX_BYTES=64, 72-byte frame -> 8 beats, 8th with o_last=1, o_err=1.
- Assert i_rst for 1 cycle during word 3 -> all outputs 0 immediately, counters 0, next frame decoded correctly.

Source files
------------

// File: rtl/mii_rx_deframer.sv
// Receive-side MII deframer: strips start/preamble/SFD and terminate characters
// from 64-bit MII words, emitting a byte-enabled payload stream with frame counters.
module mii_rx_deframer #(
   parameter int DATA_WIDTH = 64,
   parameter int CTRL_WIDTH = 8,
   parameter int MAX_BYTES  = 1518
) (
   input  logic                  clk,
   input  logic                  i_rst,
   input  logic [DATA_WIDTH-1:0] i_rx_data,
   input  logic [CTRL_WIDTH-1:0] i_rx_ctrl,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic [CTRL_WIDTH-1:0] o_keep,
   output logic                  o_valid,
   output logic                  o_last,
   output logic                  o_err,
   output logic [15:0]           o_frame_cnt,
   output logic [15:0]           o_err_cnt
);

   localparam int LW = $clog2(CTRL_WIDTH) + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DATA = 2'd1;
   localparam logic [1:0] S_DROP = 2'd2;

   localparam logic [7:0] C_IDLE  = 8'h07;
   localparam logic [7:0] C_START = 8'hFB;
   localparam logic [7:0] C_TERM  = 8'hFD;
   localparam logic [7:0] C_PRE   = 8'h55;
   localparam logic [7:0] C_SFD   = 8'hD5;

   localparam logic [15:0]           MAX_CNT   = 16'(MAX_BYTES);
   localparam logic [CTRL_WIDTH-1:0] FULL_KEEP = '1;

   logic [1:0]            r_state;
   logic [DATA_WIDTH-1:0] r_hold_data;
   logic [CTRL_WIDTH-1:0] r_hold_keep;
   logic                  r_hold_valid;
   logic                  r_hold_final;
   logic [15:0]           r_byte_cnt;
   logic [DATA_WIDTH-1:0] r_o_data;
   logic [CTRL_WIDTH-1:0] r_o_keep;
   logic                  r_o_valid;
   logic                  r_o_last;
   logic                  r_o_err;
   logic [15:0]           r_frame_cnt;
   logic [15:0]           r_err_cnt;

   logic [LW-1:0]         w_first_lane;
   logic [7:0]            w_first_char;
   logic                  w_any_ctrl;
   logic                  w_any_term;
   logic                  w_all_idle;
   logic                  w_is_start;
   logic                  w_good_start;
   logic [DATA_WIDTH-1:0] w_part_data;
   logic [CTRL_WIDTH-1:0] w_part_keep;
   logic [15:0]           w_cnt_full;
   logic [15:0]           w_cnt_part;

   logic [1:0]            w_state_nxt;
   logic [DATA_WIDTH-1:0] w_hold_data_nxt;
   logic [CTRL_WIDTH-1:0] w_hold_keep_nxt;
   logic                  w_hold_valid_nxt;
   logic                  w_hold_final_nxt;
   logic [15:0]           w_cnt_nxt;
   logic                  w_out_valid;
   logic                  w_out_last;
   logic                  w_out_err;
   logic                  w_err_evt;
   logic                  w_abort;
   logic                  w_frame_inc;
   logic                  w_err_inc;

   // Character decode: lowest control lane wins, scanned from the top down.
   always_comb begin
      w_first_lane = LW'(CTRL_WIDTH);
      w_first_char = 8'h00;
      w_any_term   = 1'b0;
      w_all_idle   = 1'b1;
      w_good_start = (i_rx_ctrl[CTRL_WIDTH-1:1] == '0) &&
                     (i_rx_data[DATA_WIDTH-1 -: 8] == C_SFD);
      for (int j = CTRL_WIDTH - 1; j >= 0; j--) begin
         if (i_rx_ctrl[j]) begin
            w_first_lane = LW'(j);
            w_first_char = i_rx_data[8*j +: 8];
            if (i_rx_data[8*j +: 8] == C_TERM) w_any_term = 1'b1;
         end
         if (!(i_rx_ctrl[j] && (i_rx_data[8*j +: 8] == C_IDLE))) w_all_idle = 1'b0;
      end
      for (int j = 1; j < CTRL_WIDTH - 1; j++) begin
         if (i_rx_data[8*j +: 8] != C_PRE) w_good_start = 1'b0;
      end
      for (int j = 0; j < CTRL_WIDTH; j++) begin
         w_part_keep[j]       = (LW'(j) < w_first_lane);
         w_part_data[8*j +: 8] = w_part_keep[j] ? i_rx_data[8*j +: 8] : 8'h00;
      end
   end

   assign w_any_ctrl = |i_rx_ctrl;
   assign w_is_start = i_rx_ctrl[0] && (i_rx_data[7:0] == C_START);
   assign w_cnt_full = r_byte_cnt + 16'(CTRL_WIDTH);
   assign w_cnt_part = r_byte_cnt + 16'(w_first_lane);

   always_comb begin
      // NOTE: every signal gets a default before any branch so no latch is inferred.
      w_state_nxt      = r_state;
      w_hold_data_nxt  = r_hold_data;
      w_hold_keep_nxt  = r_hold_keep;
      w_hold_valid_nxt = r_hold_valid;
      w_hold_final_nxt = r_hold_final;
      w_cnt_nxt        = r_byte_cnt;
      w_out_valid      = 1'b0;
      w_out_last       = 1'b0;
      w_out_err        = 1'b0;
      w_err_evt        = 1'b0;
      w_abort          = 1'b0;

      // A partial word left by a terminate drains regardless of the new input.
      if (r_hold_valid && r_hold_final) begin
         w_out_valid      = 1'b1;
         w_out_last       = 1'b1;
         w_hold_valid_nxt = 1'b0;
         w_hold_final_nxt = 1'b0;
      end

      case (r_state)
         S_IDLE: begin
            if (w_is_start) begin
               if (w_good_start) begin
                  w_state_nxt = S_DATA;
                  w_cnt_nxt   = '0;
               end else begin
                  w_state_nxt = S_DROP;
                  w_err_evt   = 1'b1;
               end
            end
         end
         S_DATA: begin
            if (!w_any_ctrl) begin
               if (w_cnt_full > MAX_CNT) begin
                  w_abort = 1'b1;
               end else begin
                  w_out_valid      = r_hold_valid;
                  w_hold_valid_nxt = 1'b1;
                  w_hold_data_nxt  = i_rx_data;
                  w_hold_keep_nxt  = FULL_KEEP;
                  w_cnt_nxt        = w_cnt_full;
               end
            end else if (w_first_char == C_TERM) begin
               if (w_cnt_part > MAX_CNT) begin
                  w_abort = 1'b1;
               end else if (w_first_lane == '0) begin
                  w_state_nxt      = S_IDLE;
                  w_hold_valid_nxt = 1'b0;
                  w_out_valid      = r_hold_valid;
                  w_out_last       = r_hold_valid;
                  w_err_evt        = !r_hold_valid;
               end else begin
                  w_state_nxt      = S_IDLE;
                  w_out_valid      = r_hold_valid;
                  w_hold_valid_nxt = 1'b1;
                  w_hold_final_nxt = 1'b1;
                  w_hold_data_nxt  = w_part_data;
                  w_hold_keep_nxt  = w_part_keep;
                  w_cnt_nxt        = w_cnt_part;
               end
            end else begin
               w_abort = 1'b1;
            end

            if (w_abort) begin
               w_state_nxt      = S_DROP;
               w_hold_valid_nxt = 1'b0;
               w_out_valid      = r_hold_valid;
               w_out_last       = r_hold_valid;
               w_out_err        = r_hold_valid;
               w_err_evt        = !r_hold_valid;
            end
         end
         S_DROP: begin
            if (w_any_term || w_all_idle) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_frame_inc = w_out_valid && w_out_last && !w_out_err;
   assign w_err_inc   = (w_out_valid && w_out_last && w_out_err) || w_err_evt;

   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_hold_data  <= '0;
         r_hold_keep  <= '0;
         r_hold_valid <= 1'b0;
         r_hold_final <= 1'b0;
         r_byte_cnt   <= '0;
         r_o_data     <= '0;
         r_o_keep     <= '0;
         r_o_valid    <= 1'b0;
         r_o_last     <= 1'b0;
         r_o_err      <= 1'b0;
         r_frame_cnt  <= '0;
         r_err_cnt    <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         r_state      <= w_state_nxt;
         r_hold_data  <= w_hold_data_nxt;
         r_hold_keep  <= w_hold_keep_nxt;
         r_hold_valid <= w_hold_valid_nxt;
         r_hold_final <= w_hold_final_nxt;
         r_byte_cnt   <= w_cnt_nxt;
         r_o_data     <= w_out_valid ? r_hold_data : '0;
         r_o_keep     <= w_out_valid ? r_hold_keep : '0;
         r_o_valid    <= w_out_valid;
         r_o_last     <= w_out_last;
         r_o_err      <= w_out_err;
         if (w_frame_inc && (r_frame_cnt != 16'hFFFF)) r_frame_cnt <= r_frame_cnt + 16'd1;
         if (w_err_inc && (r_err_cnt != 16'hFFFF))     r_err_cnt   <= r_err_cnt + 16'd1;
      end
   end

   assign o_data      = r_o_data;
   assign o_keep      = r_o_keep;
   assign o_valid     = r_o_valid;
   assign o_last      = r_o_last;
   assign o_err       = r_o_err;
   assign o_frame_cnt = r_frame_cnt;
   assign o_err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_mii_rx_deframer.sv
// Table-driven bench for mii_rx_deframer: one row per MII word with the outputs
// expected right after that word's clock edge, plus a hand-written reset sequence.
module tb_mii_rx_deframer;

   typedef struct {
      logic [63:0] d;
      logic [7:0]  c;
      logic        ev;
      logic [63:0] ed;
      logic [7:0]  ek;
      logic        el;
      logic        ee;
      logic        sm;
      logic [15:0] fc;
      logic [15:0] ec;
   } vec_t;

   localparam logic [63:0] IDLE_D  = {8{8'h07}};
   localparam logic [63:0] START_D = {8'hD5, {6{8'h55}}, 8'hFB};
   localparam logic [63:0] BADSFD  = {8'h55, {6{8'h55}}, 8'hFB};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] rx_data = IDLE_D;
   logic [7:0]  rx_ctrl = 8'hFF;

   logic [63:0] m_data, s_data;
   logic [7:0]  m_keep, s_keep;
   logic        m_valid, s_valid, m_last, s_last, m_err, s_err;
   logic [15:0] m_fcnt, s_fcnt, m_ecnt, s_ecnt;

   int n_checks = 0;
   int n_errors = 0;
   int cur_row  = 0;

   logic [15:0] bf, be;
   logic        bsm;
   vec_t        q[$];

   always #5 clk = ~clk;

   mii_rx_deframer dut (
      .clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_ctrl(rx_ctrl),
      .o_data(m_data), .o_keep(m_keep), .o_valid(m_valid), .o_last(m_last),
      .o_err(m_err), .o_frame_cnt(m_fcnt), .o_err_cnt(m_ecnt)
   );

   mii_rx_deframer #(.MAX_BYTES(64)) dut_small (
      .clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_ctrl(rx_ctrl),
      .o_data(s_data), .o_keep(s_keep), .o_valid(s_valid), .o_last(s_last),
      .o_err(s_err), .o_frame_cnt(s_fcnt), .o_err_cnt(s_ecnt)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL row %0d %s: got %h expected %h", cur_row, name, act, exp);
      end
   endtask

   function automatic logic [63:0] dw(input logic [7:0] base);
      logic [63:0] w;
      for (int k = 0; k < 8; k++) w[8*k +: 8] = base + 8'(k);
      return w;
   endfunction

   // Payload bytes below lane k, character ch in lane k, idles above.
   function automatic logic [63:0] ctl_d(input logic [7:0] base, input int k, input logic [7:0] ch);
      logic [63:0] w;
      for (int j = 0; j < 8; j++)
         w[8*j +: 8] = (j < k) ? base + 8'(j) : ((j == k) ? ch : 8'h07);
      return w;
   endfunction

   function automatic logic [7:0] ctl_c(input int k);
      logic [7:0] c;
      for (int j = 0; j < 8; j++) c[j] = (j >= k);
      return c;
   endfunction

   function automatic logic [63:0] kmask(input logic [7:0] keep);
      logic [63:0] m;
      for (int j = 0; j < 8; j++) m[8*j +: 8] = {8{keep[j]}};
      return m;
   endfunction

   task automatic add(input logic [63:0] d, input logic [7:0] c, input logic ev,
                      input logic [63:0] ed, input logic [7:0] ek, input logic el, input logic ee);
      vec_t v;
      v.d = d; v.c = c; v.ev = ev; v.ed = ed; v.ek = ek; v.el = el; v.ee = ee;
      v.sm = bsm; v.fc = bf; v.ec = be;
      q.push_back(v);
   endtask

   task automatic add_none(input logic [63:0] d, input logic [7:0] c);
      add(d, c, 1'b0, '0, '0, 1'b0, 1'b0);
   endtask

   task automatic apply_row(input vec_t v);
      logic [63:0] ad;
      logic [7:0]  ak;
      logic        av, al, ae;
      logic [15:0] afc, aec;
      @(negedge clk);
      rx_data = v.d;
      rx_ctrl = v.c;
      @(posedge clk);
      #1;
      ad  = v.sm ? s_data  : m_data;
      ak  = v.sm ? s_keep  : m_keep;
      av  = v.sm ? s_valid : m_valid;
      al  = v.sm ? s_last  : m_last;
      ae  = v.sm ? s_err   : m_err;
      afc = v.sm ? s_fcnt  : m_fcnt;
      aec = v.sm ? s_ecnt  : m_ecnt;
      check("valid", 64'(av), 64'(v.ev));
      if (v.ev) begin
         check("keep", 64'(ak), 64'(v.ek));
         check("data", ad & kmask(v.ek), v.ed & kmask(v.ek));
         check("last", 64'(al), 64'(v.el));
         check("err",  64'(ae), 64'(v.ee));
      end
      check("frame_cnt", 64'(afc), 64'(v.fc));
      check("err_cnt",   64'(aec), 64'(v.ec));
      cur_row++;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_m_out"}, {m_data}, 64'h0);
      check({tag, "_m_ctl"}, 64'({m_keep, m_valid, m_last, m_err}), 64'h0);
      check({tag, "_m_cnt"}, 64'({m_fcnt, m_ecnt}), 64'h0);
      check({tag, "_s_ctl"}, 64'({s_keep, s_valid, s_last, s_err}), 64'h0);
      check({tag, "_s_cnt"}, 64'({s_fcnt, s_ecnt}), 64'h0);
   endtask

   initial begin
      bf = 0; be = 0; bsm = 1'b0;

      // 64-byte frame, terminate in lane 0.
      add_none(IDLE_D, 8'hFF);
      add_none(START_D, 8'h01);
      add_none(dw(8'h00), 8'h00);
      for (int i = 1; i < 8; i++)
         add(dw(8'(8*i)), 8'h00, 1'b1, dw(8'(8*(i-1))), 8'hFF, 1'b0, 1'b0);
      bf = 1;
      add(ctl_d(8'h00, 0, 8'hFD), 8'hFF, 1'b1, dw(8'h38), 8'hFF, 1'b1, 1'b0);
      add_none(IDLE_D, 8'hFF);

      // 61-byte frame, terminate in lane 5, next start immediately after.
      add_none(START_D, 8'h01);
      add_none(dw(8'h40), 8'h00);
      for (int i = 1; i < 7; i++)
         add(dw(8'(8'h40 + 8*i)), 8'h00, 1'b1, dw(8'(8'h40 + 8*(i-1))), 8'hFF, 1'b0, 1'b0);
      add(ctl_d(8'h78, 5, 8'hFD), ctl_c(5), 1'b1, dw(8'h70), 8'hFF, 1'b0, 1'b0);
      bf = 2;
      add(START_D, 8'h01, 1'b1, ctl_d(8'h78, 5, 8'hFD), 8'h1F, 1'b1, 1'b0);

      // Error character in lane 3 after four words, then a short good frame.
      add_none(dw(8'h80), 8'h00);
      add(dw(8'h88), 8'h00, 1'b1, dw(8'h80), 8'hFF, 1'b0, 1'b0);
      add(dw(8'h90), 8'h00, 1'b1, dw(8'h88), 8'hFF, 1'b0, 1'b0);
      add(dw(8'h98), 8'h00, 1'b1, dw(8'h90), 8'hFF, 1'b0, 1'b0);
      be = 1;
      add(ctl_d(8'hA0, 3, 8'hFE), 8'hF8, 1'b1, dw(8'h98), 8'hFF, 1'b1, 1'b1);
      add_none(IDLE_D, 8'hFF);
      add_none(START_D, 8'h01);
      add_none(dw(8'hB0), 8'h00);
      bf = 3;
      add(ctl_d(8'h00, 0, 8'hFD), 8'hFF, 1'b1, dw(8'hB0), 8'hFF, 1'b1, 1'b0);
      add_none(IDLE_D, 8'hFF);

      // Bad SFD, a start ignored while dropping, then a good frame ending in lane 2.
      be = 2;
      add_none(BADSFD, 8'h01);
      add_none(START_D, 8'h01);
      add_none(dw(8'hC0), 8'h00);
      add_none(IDLE_D, 8'hFF);
      add_none(START_D, 8'h01);
      add_none(dw(8'hC8), 8'h00);
      add(dw(8'hD0), 8'h00, 1'b1, dw(8'hC8), 8'hFF, 1'b0, 1'b0);
      add(ctl_d(8'hD8, 2, 8'hFD), ctl_c(2), 1'b1, dw(8'hD0), 8'hFF, 1'b0, 1'b0);
      bf = 4;
      add(IDLE_D, 8'hFF, 1'b1, ctl_d(8'hD8, 2, 8'hFD), 8'h03, 1'b1, 1'b0);

      // 72-byte frame seen by the MAX_BYTES=64 instance: overflow abort on word 9.
      bsm = 1'b1;
      add_none(START_D, 8'h01);
      add_none(dw(8'h00), 8'h00);
      for (int i = 1; i < 8; i++)
         add(dw(8'(8*i)), 8'h00, 1'b1, dw(8'(8*(i-1))), 8'hFF, 1'b0, 1'b0);
      be = 3;
      add(dw(8'h40), 8'h00, 1'b1, dw(8'h38), 8'hFF, 1'b1, 1'b1);
      add_none(ctl_d(8'h00, 0, 8'hFD), 8'hFF);
      add_none(IDLE_D, 8'hFF);

      repeat (2) @(negedge clk);
      check_all_zero("reset_hold");
      rst = 1'b0;
      #1;
      check_all_zero("reset_release");

      for (int i = 0; i < q.size(); i++) apply_row(q[i]);

      // The full-size instance delivered the 72-byte frame as a good frame.
      check("m_frame_cnt_after_72", 64'(m_fcnt), 64'd5);
      check("m_err_cnt_after_72",   64'(m_ecnt), 64'd2);

      // Frame cut by reset during word 3, then a clean frame.
      q.delete();
      bsm = 1'b0; bf = 5; be = 2;
      add_none(START_D, 8'h01);
      add_none(dw(8'hE0), 8'h00);
      add(dw(8'hE8), 8'h00, 1'b1, dw(8'hE0), 8'hFF, 1'b0, 1'b0);
      for (int i = 0; i < q.size(); i++) apply_row(q[i]);

      @(negedge clk);
      rx_data = dw(8'hF0);
      rx_ctrl = 8'h00;
      #1 rst = 1'b1;
      #1 check_all_zero("reset_async");
      @(posedge clk);
      #1 check_all_zero("reset_edge");
      @(negedge clk);
      rst = 1'b0;

      q.delete();
      bf = 0; be = 0;
      add_none(IDLE_D, 8'hFF);
      add_none(START_D, 8'h01);
      add_none(dw(8'h10), 8'h00);
      bf = 1;
      add(ctl_d(8'h00, 0, 8'hFD), 8'hFF, 1'b1, dw(8'h10), 8'hFF, 1'b1, 1'b0);
      add_none(IDLE_D, 8'hFF);
      for (int i = 0; i < q.size(); i++) apply_row(q[i]);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
